// File: rtl/spike_pkg.sv
// Shared types and width defaults for the spike rate decoder and its neighbours.
package spike_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WIN_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int ISI_W_DEF = 8;

    localparam int unsigned WIN_MAX_DEF = (1 << WIN_W_DEF) - 1;
    localparam int unsigned CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;
    localparam int unsigned ISI_MAX_DEF = (1 << ISI_W_DEF) - 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with clear (priority over enable) that sticks at all-ones.
// o_inc is the saturated increment of the current value, so the parent can
// use "count plus this cycle's event" without waiting for the register.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_inc
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_inc = (r_cnt == MAX) ? r_cnt : r_cnt + W'(1);

    // count register: clear wins over increment
    always_ff @(posedge clk) begin
        if (rst)        r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= o_inc;
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts a 1-bit spike train into per-window spike count and minimum
// inter-spike interval, published through a valid/ready port.
//
// state | meaning
// IDLE  | decoder disabled; waiting for ena to start a fresh window
// RUN   | counting cycles k=0..len_q-1 of a window, back-to-back windows
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ISI_W = ISI_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] isi_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    state_t r_state, w_state_nxt;

    logic [WIN_W-1:0] r_len_q, r_k;
    logic [ISI_W-1:0] r_min_isi;
    logic             r_seen_first, r_isi_valid, r_spike_prev;

    logic [CNT_W-1:0] w_cnt, w_cnt_inc;
    logic [ISI_W-1:0] w_tmr, w_isi_cand;
    logic [WIN_W-1:0] w_len_eff;
    logic [ISI_W-1:0] w_min_nxt;
    logic [CNT_W-1:0] w_rate_pub;
    logic             w_evt, w_run, w_start, w_last, w_publish, w_accept;
    logic             w_isi_upd, w_two;

    assign w_evt     = spike_in & ~r_spike_prev;
    assign w_run     = (r_state == RUN);
    assign w_start   = (r_state == IDLE) && ena;
    assign w_last    = (r_k == r_len_q - WIN_W'(1));
    // ena low on the final cycle aborts rather than publishes
    assign w_publish = w_run && ena && w_last;
    assign w_accept  = out_valid && out_ready;
    assign w_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;

    assign w_isi_upd  = w_run && w_evt && r_seen_first;
    assign w_min_nxt  = (w_isi_upd && (w_isi_cand < r_min_isi)) ? w_isi_cand : r_min_isi;
    assign w_two      = r_isi_valid || w_isi_upd;
    assign w_rate_pub = w_evt ? w_cnt_inc : w_cnt;

    sat_counter #(.W(CNT_W)) u_spike_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start || w_publish),
        .i_en  (w_run && w_evt),
        .o_cnt (w_cnt),
        .o_inc (w_cnt_inc)
    );

    // ISI timer is deliberately not cleared at window boundaries
    sat_counter #(.W(ISI_W)) u_isi_tmr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_run && w_evt),
        .i_en  (w_run),
        .o_cnt (w_tmr),
        .o_inc (w_isi_cand)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state: ena alone decides between running and idling
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ena)  w_state_nxt = RUN;
            RUN:     if (!ena) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // state outputs
    always_comb begin
        busy = 1'b0;
        if (r_state == RUN) busy = 1'b1;
    end

    // window bookkeeping: length latch, cycle index, first-spike and min-ISI tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spike_prev <= 1'b0;
            r_len_q      <= '0;
            r_k          <= '0;
            r_min_isi    <= '0;
            r_seen_first <= 1'b0;
            r_isi_valid  <= 1'b0;
        end else begin
            r_spike_prev <= spike_in;
            if (w_start || w_publish) begin
                r_len_q      <= w_len_eff;
                r_k          <= '0;
                r_min_isi    <= '1;
                r_seen_first <= 1'b0;
                r_isi_valid  <= 1'b0;
            end else if (w_run) begin
                r_k       <= r_k + WIN_W'(1);
                r_min_isi <= w_min_nxt;
                if (w_evt)     r_seen_first <= 1'b1;
                if (w_isi_upd) r_isi_valid  <= 1'b1;
            end
        end
    end

    // result port: publish, handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_out  <= '0;
            isi_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_publish) begin
                rate_out  <= w_rate_pub;
                isi_out   <= w_two ? w_min_nxt : '0;
                out_valid <= 1'b1;
            end else if (w_accept) begin
                out_valid <= 1'b0;
            end
            if (w_accept)                    overrun <= 1'b0;
            else if (w_publish && out_valid) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: default-width decoder plus a narrow (CNT_W=2, ISI_W=3)
// instance sharing the same stimulus for the saturation cases.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst, ena, spike_in, out_ready;
    logic [7:0] win_len;

    logic [7:0] rate_out, isi_out;
    logic       out_valid, overrun, busy;
    logic [1:0] rate_s;
    logic [2:0] isi_s;
    logic       valid_s, overrun_s, busy_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spike_rate_decoder dut (
        .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .win_len(win_len),
        .rate_out(rate_out), .isi_out(isi_out), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .busy(busy)
    );

    spike_rate_decoder #(.WIN_W(8), .CNT_W(2), .ISI_W(3)) dut_s (
        .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .win_len(win_len),
        .rate_out(rate_s), .isi_out(isi_s), .out_valid(valid_s),
        .out_ready(out_ready), .overrun(overrun_s), .busy(busy_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // leave IDLE with a new length; returns in RUN at k=0
    task automatic start_window(input logic [7:0] len);
        ena = 1'b0; spike_in = 1'b0;
        step();
        win_len = len; ena = 1'b1;
        step();
    endtask

    // abort the running window and accept whatever is pending
    task automatic stop_and_drain();
        ena = 1'b0; spike_in = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; spike_in = 1'b0; out_ready = 1'b0; win_len = 8'd0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_rate", 32'(rate_out), 0);
        chk("reset_isi", 32'(isi_out), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_busy", 32'(busy), 0);

        // win_len=10, pulses at k=1,4,8
        start_window(8'd10);
        chk("w10_busy_start", 32'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            spike_in = (k == 1 || k == 4 || k == 8);
            if (k == 9) chk("w10_valid_before_end", 32'(out_valid), 0);
            step();
        end
        spike_in = 1'b0;
        chk("w10_valid", 32'(out_valid), 1);
        chk("w10_rate", 32'(rate_out), 3);
        chk("w10_isi", 32'(isi_out), 3);
        chk("w10_busy", 32'(busy), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("w10_accept_valid", 32'(out_valid), 0);
        chk("w10_accept_overrun", 32'(overrun), 0);
        ena = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 0);

        // level held high over a 4-cycle window counts once
        start_window(8'd4);
        spike_in = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("held_rate", 32'(rate_out), 1);
        chk("held_isi", 32'(isi_out), 0);
        chk("held_valid", 32'(out_valid), 1);
        stop_and_drain();
        chk("held_drained", 32'(out_valid), 0);

        // alternating 0/1 over two 5-cycle windows, ready held low
        start_window(8'd5);
        for (int t = 0; t < 5; t++) begin
            spike_in = (t % 2 == 1);
            step();
        end
        chk("alt_w1_rate", 32'(rate_out), 2);
        chk("alt_w1_isi", 32'(isi_out), 2);
        chk("alt_w1_overrun", 32'(overrun), 0);
        for (int t = 5; t < 10; t++) begin
            spike_in = (t % 2 == 1);
            step();
        end
        chk("alt_w2_rate", 32'(rate_out), 3);
        chk("alt_w2_isi", 32'(isi_out), 2);
        chk("alt_w2_valid", 32'(out_valid), 1);
        chk("alt_w2_overrun", 32'(overrun), 1);
        spike_in = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("alt_ready_valid", 32'(out_valid), 0);
        chk("alt_ready_overrun", 32'(overrun), 0);
        stop_and_drain();

        // 10 events in a 20-cycle window: narrow count saturates at 3
        start_window(8'd20);
        for (int k = 0; k < 20; k++) begin
            spike_in = (k % 2 == 0);
            step();
        end
        chk("cntsat_rate_narrow", 32'(rate_s), 3);
        chk("cntsat_rate_wide", 32'(rate_out), 10);
        chk("cntsat_isi_narrow", 32'(isi_s), 2);
        chk("cntsat_busy_narrow", 32'(busy_s), 1);
        stop_and_drain();

        // spikes 12 apart: narrow ISI saturates at 7
        start_window(8'd30);
        for (int k = 0; k < 30; k++) begin
            spike_in = (k == 0 || k == 12 || k == 24);
            step();
        end
        chk("isisat_isi_narrow", 32'(isi_s), 7);
        chk("isisat_isi_wide", 32'(isi_out), 12);
        chk("isisat_rate_narrow", 32'(rate_s), 3);
        chk("isisat_valid_narrow", 32'(valid_s), 1);
        stop_and_drain();
        chk("isisat_overrun_narrow", 32'(overrun_s), 0);

        // ena dropped at k=5 after two spikes: nothing published
        start_window(8'd10);
        for (int k = 0; k < 5; k++) begin
            spike_in = (k == 1 || k == 3);
            step();
        end
        spike_in = 1'b0; ena = 1'b0;
        step();
        chk("abort5_busy", 32'(busy), 0);
        chk("abort5_valid", 32'(out_valid), 0);
        start_window(8'd4);
        for (int k = 0; k < 4; k++) begin
            spike_in = (k == 2);
            step();
        end
        chk("fresh_rate", 32'(rate_out), 1);
        chk("fresh_isi", 32'(isi_out), 0);
        stop_and_drain();

        // win_len=0 behaves as 1-cycle windows, continuous accepts
        start_window(8'd0);
        out_ready = 1'b1;
        spike_in = 1'b1;
        step();
        chk("w0_c0_valid", 32'(out_valid), 1);
        chk("w0_c0_rate", 32'(rate_out), 1);
        spike_in = 1'b0;
        step();
        chk("w0_c1_valid", 32'(out_valid), 1);
        chk("w0_c1_rate", 32'(rate_out), 0);
        chk("w0_c1_overrun", 32'(overrun), 0);
        spike_in = 1'b1;
        step();
        chk("w0_c2_valid", 32'(out_valid), 1);
        chk("w0_c2_rate", 32'(rate_out), 1);
        chk("w0_c2_isi", 32'(isi_out), 0);

        // reset mid-window with a pending result
        out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; ena = 1'b0; spike_in = 1'b0;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_rate", 32'(rate_out), 0);
        chk("midrst_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receive-side companion to the LIF neuron core. Takes the neuron's 1-bit spike output and converts the spike train back into numbers: spike count per programmable window and minimum inter-spike interval (ISI) within that window. Results are published through a valid/ready output port, so the on-chip readout mux or a host-facing shift stage can sample them.

Parameters:
WIN_W, 8, width of win_len; window length range 1..2^WIN_W-1 cycles
CNT_W, 8, width of rate_out; spike count saturates at 2^CNT_W-1
ISI_W, 8, width of isi_out; ISI saturates at 2^ISI_W-1

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
ena  input  1  decoder enable; low aborts the current window
spike_in  input  1  spike from neuron core (uio_out[7] of the neuron)
win_len  input  WIN_W  window length in cycles; sampled at window start; 0 treated as 1
rate_out  output  CNT_W  spike count of the last completed window
isi_out  output  ISI_W  minimum ISI in the last window; 0 if fewer than 2 spikes
out_valid  output  1  result available
out_ready  input  1  consumer accepts result when out_valid and out_ready are both high
overrun  output  1  sticky: a result was overwritten before acceptance
busy  output  1  high while in RUN

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; rate_out=0, isi_out=0, out_valid=0, overrun=0, busy=0; internal count, ISI timer, min-ISI, window index, and spike_prev all 0.
- Edge detect: a spike event occurs in cycle t when spike_in=1 and spike_prev=0. spike_prev follows spike_in every cycle in all states. A level held high counts once.
- FSM IDLE: busy=0. When ena=1, latch win_len (0->1) into len_q, clear count, ISI-valid flag, and min-ISI (to all-ones), set window index k=0. Go to RUN next cycle.
- FSM RUN: busy=1. Each cycle k=0..len_q-1:
  - A spike event increments count, saturating at 2^CNT_W-1.
  - ISI timer counts cycles since the last spike event, saturating at 2^ISI_W-1. On an event after the first, compare timer+1 with min-ISI and keep the smaller value, then clear the timer. The ISI timer persists across window boundaries; the "first spike seen" flag does not.
- Window end: at the clock edge closing cycle k=len_q-1, including any event in that cycle:
  - rate_out <= count.
  - isi_out <= min-ISI if 2 or more events occurred, else 0.
  - out_valid <= 1.
  - Counters clear. win_len is re-latched. Next cycle is k=0 of the next window, so there are no dead cycles.
- Handshake:
  - out_valid drops the cycle after out_valid and out_ready are both high, unless a new result is published on that same edge. In that case out_valid stays 1 with the new data, and overrun is not set.
  - Publishing while out_valid=1 and out_ready=0 overwrites data and sets overrun=1.
  - overrun clears only on an accepted handshake.
  - rate_out and isi_out are stable while out_valid=1 and not accepted, except on overrun.
- ena low in RUN: abort at the next edge. Go to IDLE with nothing published, partial counts discarded. Pending out_valid, data, and overrun are retained. When ena returns, a fresh window starts.
- rst mid-window or mid-handshake returns everything to reset values on the next edge.
- Latency: spike event in cycle k appears in rate_out len_q-k cycles later.

Decomposition:
- Shared package spike_pkg: state enum (IDLE, RUN) and saturating-max constants derived from the widths, reused by the neuron bench and readout mux.
- One natural sub-module: sat_counter, a parameterized-width up-counter with clear, enable, and saturation. It is instantiated for the spike count and the ISI timer.

Test Plan:
- Reset then ena=1, win_len=10, spike pulses at k=1,4,8 -> out_valid=1 after 10 RUN cycles; rate_out=3, isi_out=3; busy=1.
- win_len=4 with spike_in held high for the whole window -> rate_out=1, isi_out=0 (one event only).
- win_len=5 with spikes every cycle alternating 1/0 and out_ready tied 0 across two windows -> rate_out=3 from the second window, overrun=1. One ready pulse clears out_valid and overrun.
- Count saturation: CNT_W=2, win_len=20, 10 spike events -> rate_out=3. ISI saturation: ISI_W=3, spikes 12 cycles apart -> isi_out=7.
- ena dropped at k=5 of a 10-cycle window after 2 spikes -> no publish, busy=0. Re-enable gives a fresh window whose count excludes the earlier spikes.
- win_len=0 -> 1-cycle windows. A spike event on a given cycle publishes rate_out=1 the next cycle. Back-to-back accepts with out_ready=1 keep out_valid high continuously.
